// File: rtl/daq_pkg.sv
// Shared types and constants for the AD capture -> USB packing path.
package daq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush
    } state_e;

    localparam int unsigned FRAME_WORDS = 256;
    localparam int unsigned FIFO_DEPTH  = 16;
    localparam logic [15:0] PAD_WORD    = 16'h0000;

    // Output word plus the frame-end marker travel together through the FIFO.
    localparam int unsigned FIFO_WIDTH  = 17;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ad_frame_packer_if.sv
// Ready/valid stream from the frame packer toward the USB FIFO writer.
interface ad_frame_packer_if;

    logic [15:0] m_data_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic        m_last_o;

    modport master (
        output m_data_o,
        output m_valid_o,
        output m_last_o,
        input  m_ready_i
    );

    modport slave (
        input  m_data_o,
        input  m_valid_o,
        input  m_last_o,
        output m_ready_i
    );

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with synchronous active-low reset.
module sync_fifo #(
    parameter int unsigned Width = 17,
    parameter int unsigned Depth = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [Width-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_fire, rd_fire;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(Depth - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full_o  = (count_q == CW'(Depth));
    assign empty_o = (count_q == '0);
    assign wr_fire = wr_en_i & ~full_o;
    assign rd_fire = rd_en_i & ~empty_o;

    // Zero the head when empty so an idle bus reads as a clean 0.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_fire) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_fire) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/ad_frame_packer.sv
// Decimates ADC samples, tags them with a 4-bit sequence number and packs them
// into 256-word frames, padding the tail of a frame when capture stops.
module ad_frame_packer
    import daq_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [11:0]              ad_data_i,
    input  logic                     start_i,
    input  logic [7:0]               decim_i,
    ad_frame_packer_if.master        m_if,
    output logic                     busy_o,
    output logic                     ovf_o,
    output logic [15:0]              drop_cnt_o
);

    localparam logic [7:0] FRAME_LAST = 8'(FRAME_WORDS - 1);

    state_e      state_q, state_d;
    logic [7:0]  decim_q, decim_d;
    logic [7:0]  dec_cnt_q, dec_cnt_d;
    logic [3:0]  seq_q, seq_d;
    logic [7:0]  frame_q, frame_d;
    logic        ovf_q, ovf_d;
    logic [15:0] drop_q, drop_d;

    logic                  fifo_wr, fifo_rd;
    logic [FIFO_WIDTH-1:0] fifo_wdata, fifo_rdata;
    logic                  fifo_full, fifo_empty;

    always_comb begin
        state_d    = state_q;
        decim_d    = decim_q;
        dec_cnt_d  = dec_cnt_q;
        seq_d      = seq_q;
        frame_d    = frame_q;
        ovf_d      = ovf_q;
        drop_d     = drop_q;
        fifo_wr    = 1'b0;
        fifo_wdata = '0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d   = StRun;
                    decim_d   = decim_i;
                    dec_cnt_d = '0;
                    seq_d     = '0;
                    frame_d   = '0;
                    ovf_d     = 1'b0;
                    drop_d    = '0;
                end
            end
            StRun: begin
                if (!start_i) begin
                    state_d = StFlush;
                end else if (dec_cnt_q == '0) begin
                    dec_cnt_d = decim_q;
                    // Dropped samples still consume a sequence number so gaps are visible.
                    seq_d     = seq_q + 4'd1;
                    if (fifo_full) begin
                        ovf_d  = 1'b1;
                        drop_d = sat_inc16(drop_q);
                    end else begin
                        fifo_wr    = 1'b1;
                        fifo_wdata = {(frame_q == FRAME_LAST), seq_q, ad_data_i};
                        frame_d    = frame_q + 8'd1;
                    end
                end else begin
                    dec_cnt_d = dec_cnt_q - 8'd1;
                end
            end
            StFlush: begin
                if (frame_q != '0) begin
                    // Pads wait for space rather than being lost.
                    if (!fifo_full) begin
                        fifo_wr    = 1'b1;
                        fifo_wdata = {(frame_q == FRAME_LAST), PAD_WORD};
                        frame_d    = frame_q + 8'd1;
                    end
                end else if (fifo_empty) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= StIdle;
            decim_q   <= '0;
            dec_cnt_q <= '0;
            seq_q     <= '0;
            frame_q   <= '0;
            ovf_q     <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            decim_q   <= decim_d;
            dec_cnt_q <= dec_cnt_d;
            seq_q     <= seq_d;
            frame_q   <= frame_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
        end
    end

    sync_fifo #(
        .Width (FIFO_WIDTH),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .wr_en_i   (fifo_wr),
        .wr_data_i (fifo_wdata),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign fifo_rd        = ~fifo_empty & m_if.m_ready_i;
    assign m_if.m_valid_o = ~fifo_empty;
    assign m_if.m_data_o  = fifo_rdata[15:0];
    assign m_if.m_last_o  = fifo_rdata[16];

    assign busy_o     = (state_q != StIdle);
    assign ovf_o      = ovf_q;
    assign drop_cnt_o = drop_q;

    // A stalled output word must not change until it is taken.
    a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (m_if.m_valid_o && !m_if.m_ready_i) |=>
            (m_if.m_valid_o && $stable({m_if.m_last_o, m_if.m_data_o})));

endmodule

// File: tb/tb_ad_frame_packer.sv
// Self-checking bench for ad_frame_packer: a queue-based model predicts every
// handshaken output word and the cycle it is taken.
module tb_ad_frame_packer;
    import daq_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [11:0] ad_data_i;
    logic        start_i;
    logic [7:0]  decim_i;
    logic        busy_o, ovf_o;
    logic [15:0] drop_cnt_o;

    ad_frame_packer_if m_if();

    ad_frame_packer dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .ad_data_i  (ad_data_i),
        .start_i    (start_i),
        .decim_i    (decim_i),
        .m_if       (m_if),
        .busy_o     (busy_o),
        .ovf_o      (ovf_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int          got_cyc[$];
    logic [16:0] got_w[$];
    int          exp_cyc[$];
    logic [16:0] exp_w[$];

    // Reference model: 0 idle, 1 run, 2 flush; m_q holds buffered {last, word}.
    int          m_st, m_dlat, m_runcyc, m_seq, m_frame, m_drop;
    bit          m_ovf;
    logic [16:0] m_q[$];

    task automatic mdl_edge();
        int sz   = m_q.size();
        bit full = (sz == FIFO_DEPTH);
        if (!rst_n_i) begin
            m_q.delete();
            m_st = 0; m_dlat = 0; m_runcyc = 0; m_seq = 0; m_frame = 0; m_ovf = 0; m_drop = 0;
            return;
        end
        if (sz > 0 && m_if.m_ready_i) begin
            exp_cyc.push_back(cyc + 1);
            exp_w.push_back(m_q.pop_front());
        end
        case (m_st)
            0: if (start_i) begin
                m_st = 1; m_dlat = int'(decim_i); m_runcyc = 0;
                m_seq = 0; m_frame = 0; m_ovf = 0; m_drop = 0;
            end
            1: if (!start_i) begin
                m_st = 2;
            end else begin
                if (m_runcyc % (m_dlat + 1) == 0) begin
                    if (full) begin
                        m_ovf = 1;
                        if (m_drop < 65535) m_drop++;
                    end else begin
                        m_q.push_back({(m_frame == 255), 4'(m_seq), ad_data_i});
                        m_frame = (m_frame + 1) % 256;
                    end
                    m_seq = (m_seq + 1) % 16;
                end
                m_runcyc++;
            end
            2: if (m_frame != 0) begin
                if (!full) begin
                    m_q.push_back({(m_frame == 255), PAD_WORD});
                    m_frame = (m_frame + 1) % 256;
                end
            end else if (sz == 0) begin
                m_st = 0;
            end
            default: ;
        endcase
    endtask

    task automatic step();
        mdl_edge();
        @(posedge clk_i);
        cyc++;
        #1;
    endtask

    task automatic clr();
        got_cyc.delete(); got_w.delete(); exp_cyc.delete(); exp_w.delete();
    endtask

    task automatic drain(output bit ok);
        start_i = 1'b0;
        m_if.m_ready_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_n_i && m_if.m_valid_o && m_if.m_ready_i) begin
            got_cyc.push_back(cyc + 1);
            got_w.push_back({m_if.m_last_o, m_if.m_data_o});
        end
    end

    task automatic test_reset();
        rst_n_i = 1'b0; start_i = 1'b0; decim_i = '0; ad_data_i = '0; m_if.m_ready_i = 1'b0;
        step(); step();
        n_tests += 6;
        if (m_if.m_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", m_if.m_valid_o); end
        if (m_if.m_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", m_if.m_last_o); end
        if (m_if.m_data_o !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h want 0000", m_if.m_data_o); end
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
        if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf_o); end
        if (drop_cnt_o !== 16'h0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_cnt_o); end
        rst_n_i = 1'b1;
        step();
    endtask

    task automatic test_decim0();
        bit ok;
        clr();
        decim_i = 8'd0; m_if.m_ready_i = 1'b1; start_i = 1'b1; ad_data_i = '0;
        step();
        for (int i = 0; i < 300; i++) begin
            ad_data_i = 12'(i);
            step();
        end
        drain(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL decim0_drain busy stuck, want idle"); end
        n_tests++;
        if (got_w.size() != exp_w.size()) begin
            n_fail++; $display("FAIL decim0_count got %0d want %0d", got_w.size(), exp_w.size());
        end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            n_tests++;
            if (got_w[i] !== exp_w[i] || got_cyc[i] != exp_cyc[i]) begin
                n_fail++;
                $display("FAIL decim0_word[%0d] got %h@%0d want %h@%0d", i, got_w[i], got_cyc[i], exp_w[i], exp_cyc[i]);
            end
        end
        n_tests++;
        if (got_w.size() < 256) begin
            n_fail++; $display("FAIL decim0_len got %0d want >=256", got_w.size());
        end else begin
            if (got_w[0] !== 17'h00000) begin n_fail++; $display("FAIL decim0_w0 got %h want 00000", got_w[0]); end
            n_tests++;
            if (got_w[1] !== 17'h01001) begin n_fail++; $display("FAIL decim0_w1 got %h want 01001", got_w[1]); end
            n_tests++;
            if (got_w[255] !== 17'h1f0ff) begin n_fail++; $display("FAIL decim0_w255 got %h want 1f0ff", got_w[255]); end
            n_tests++;
            if (got_w[254][16] !== 1'b0) begin n_fail++; $display("FAIL decim0_last254 got %b want 0", got_w[254][16]); end
        end
    endtask

    task automatic test_decim3();
        bit ok;
        clr();
        decim_i = 8'd3; m_if.m_ready_i = 1'b1; start_i = 1'b1; ad_data_i = '0;
        step();
        decim_i = 8'd0;  // must be ignored: value was latched on entry
        for (int i = 0; i < 40; i++) begin
            ad_data_i = 12'(i);
            step();
        end
        drain(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL decim3_drain busy stuck, want idle"); end
        n_tests++;
        if (got_w.size() != exp_w.size()) begin
            n_fail++; $display("FAIL decim3_count got %0d want %0d", got_w.size(), exp_w.size());
        end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            n_tests++;
            if (got_w[i] !== exp_w[i] || got_cyc[i] != exp_cyc[i]) begin
                n_fail++;
                $display("FAIL decim3_word[%0d] got %h@%0d want %h@%0d", i, got_w[i], got_cyc[i], exp_w[i], exp_cyc[i]);
            end
        end
        n_tests++;
        if (got_w.size() < 3 || got_w[1] !== 17'h01004 || got_w[2] !== 17'h02008) begin
            n_fail++; $display("FAIL decim3_samples got size %0d, want words 01004,02008 at 1,2", got_w.size());
        end
    endtask

    task automatic test_overflow();
        bit ok;
        clr();
        decim_i = 8'd0; m_if.m_ready_i = 1'b0; start_i = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            if (i == 19) m_if.m_ready_i = 1'b1;
            ad_data_i = 12'($urandom);
            step();
        end
        n_tests += 2;
        if (ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", ovf_o); end
        if (drop_cnt_o !== 16'd4) begin n_fail++; $display("FAIL ovf_drop got %0d want 4", drop_cnt_o); end
        for (int i = 0; i < 10; i++) begin
            ad_data_i = 12'($urandom);
            step();
        end
        drain(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL ovf_drain busy stuck, want idle"); end
        n_tests++;
        if (got_w.size() != exp_w.size()) begin
            n_fail++; $display("FAIL ovf_count got %0d want %0d", got_w.size(), exp_w.size());
        end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            n_tests++;
            if (got_w[i] !== exp_w[i] || got_cyc[i] != exp_cyc[i]) begin
                n_fail++;
                $display("FAIL ovf_word[%0d] got %h@%0d want %h@%0d", i, got_w[i], got_cyc[i], exp_w[i], exp_cyc[i]);
            end
        end
        n_tests++;
        if (got_w.size() < 17 || got_w[15][15:12] !== 4'hf || got_w[16][15:12] !== 4'h4) begin
            n_fail++; $display("FAIL ovf_gap got size %0d, want seq f then 4 at words 15,16", got_w.size());
        end
    endtask

    task automatic test_stop_mid();
        bit ok;
        int pads;
        clr();
        decim_i = 8'd0; m_if.m_ready_i = 1'b1; start_i = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            ad_data_i = 12'($urandom);
            step();
        end
        drain(ok);
        n_tests += 2;
        if (!ok) begin n_fail++; $display("FAIL stop_drain busy stuck, want idle"); end
        if (got_w.size() != 256) begin n_fail++; $display("FAIL stop_len got %0d want 256", got_w.size()); end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            n_tests++;
            if (got_w[i] !== exp_w[i] || got_cyc[i] != exp_cyc[i]) begin
                n_fail++;
                $display("FAIL stop_word[%0d] got %h@%0d want %h@%0d", i, got_w[i], got_cyc[i], exp_w[i], exp_cyc[i]);
            end
        end
        pads = 0;
        for (int i = 10; i < got_w.size(); i++) begin
            if (got_w[i][15:0] == 16'h0000) pads++;
        end
        n_tests += 2;
        if (pads != 246) begin n_fail++; $display("FAIL stop_pads got %0d want 246", pads); end
        if (got_w.size() < 256 || got_w[255] !== 17'h10000) begin
            n_fail++; $display("FAIL stop_last_pad got size %0d, want word 255 = 10000", got_w.size());
        end
    endtask

    task automatic test_restart();
        bit idle_seen;
        clr();
        decim_i = 8'd0; start_i = 1'b1;
        m_if.m_ready_i = 1'b0;
        step();
        for (int i = 0; i < 60; i++) begin
            m_if.m_ready_i = 1'($urandom_range(0, 1));
            ad_data_i = 12'($urandom);
            step();
        end
        n_tests += 2;
        if (ovf_o !== 1'(m_ovf)) begin n_fail++; $display("FAIL restart_ovf_pre got %b want %b", ovf_o, m_ovf); end
        if (drop_cnt_o !== 16'(m_drop)) begin n_fail++; $display("FAIL restart_drop_pre got %0d want %0d", drop_cnt_o, m_drop); end
        start_i = 1'b0;
        step();
        start_i = 1'b1;
        idle_seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            m_if.m_ready_i = 1'($urandom_range(0, 1));
            step();
            if (!busy_o) begin idle_seen = 1'b1; break; end
        end
        n_tests++;
        if (!idle_seen) begin n_fail++; $display("FAIL restart_idle busy stuck, want one idle cycle"); end
        step();
        n_tests += 3;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL restart_busy got %b want 1", busy_o); end
        if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL restart_ovf got %b want 0", ovf_o); end
        if (drop_cnt_o !== 16'h0) begin n_fail++; $display("FAIL restart_drop got %0d want 0", drop_cnt_o); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clr();
        start_i = 1'b0;
        rst_n_i = 1'b0; step(); rst_n_i = 1'b1;
        decim_i = 8'd0; m_if.m_ready_i = 1'b0; start_i = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            ad_data_i = 12'($urandom);
            step();
        end
        n_tests++;
        if (m_if.m_valid_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_buffered got valid %b want 1", m_if.m_valid_o); end
        rst_n_i = 1'b0;
        step();
        n_tests += 2;
        if (m_if.m_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", m_if.m_valid_o); end
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy_o); end
        rst_n_i = 1'b1;
        clr();
        m_if.m_ready_i = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            ad_data_i = 12'($urandom);
            step();
        end
        drain(ok);
        n_tests += 3;
        if (!ok) begin n_fail++; $display("FAIL rstmid_drain busy stuck, want idle"); end
        if (got_w.size() != exp_w.size()) begin
            n_fail++; $display("FAIL rstmid_count got %0d want %0d", got_w.size(), exp_w.size());
        end
        if (got_w.size() == 0 || got_w[0][15:12] !== 4'h0) begin
            n_fail++; $display("FAIL rstmid_seq0 got size %0d, want first seq 0", got_w.size());
        end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            n_tests++;
            if (got_w[i] !== exp_w[i] || got_cyc[i] != exp_cyc[i]) begin
                n_fail++;
                $display("FAIL rstmid_word[%0d] got %h@%0d want %h@%0d", i, got_w[i], got_cyc[i], exp_w[i], exp_cyc[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int len, pct;
        for (int r = 0; r < 3; r++) begin
            clr();
            decim_i = 8'($urandom_range(0, 4));
            pct = $urandom_range(30, 100);
            len = $urandom_range(300, 700);
            start_i = 1'b1;
            for (int i = 0; i < len; i++) begin
                m_if.m_ready_i = ($urandom_range(1, 100) <= pct);
                ad_data_i = 12'($urandom);
                step();
            end
            drain(ok);
            n_tests += 4;
            if (!ok) begin n_fail++; $display("FAIL rand%0d_drain busy stuck, want idle", r); end
            if (got_w.size() != exp_w.size()) begin
                n_fail++; $display("FAIL rand%0d_count got %0d want %0d", r, got_w.size(), exp_w.size());
            end
            if (ovf_o !== 1'(m_ovf)) begin n_fail++; $display("FAIL rand%0d_ovf got %b want %b", r, ovf_o, m_ovf); end
            if (drop_cnt_o !== 16'(m_drop)) begin
                n_fail++; $display("FAIL rand%0d_drop got %0d want %0d", r, drop_cnt_o, m_drop);
            end
            for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
                n_tests++;
                if (got_w[i] !== exp_w[i] || got_cyc[i] != exp_cyc[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_word[%0d] got %h@%0d want %h@%0d", r, i, got_w[i], got_cyc[i], exp_w[i], exp_cyc[i]);
                end
            end
        end
    endtask

    initial begin
        rst_n_i = 1'b0; start_i = 1'b0; decim_i = '0; ad_data_i = '0; m_if.m_ready_i = 1'b0;
        test_reset();
        test_decim0();
        test_decim3();
        test_overflow();
        test_stop_mid();
        test_restart();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ad_frame_packer.md
AD_FRAME_PACKER -- requirements
Module: ad_frame_packer

Interface
REQ-001 SHALL have port clk_i, input, 1, sole clock, same clock as the AD capture stage.
REQ-002 SHALL have port rst_n_i, input, 1, reset that is synchronous and active-low.
REQ-003 SHALL have port ad_data_i, input, 12, registered ADC sample, one new sample every clk_i.
REQ-004 SHALL have port start_i, input, 1, capture-enable level.
REQ-005 SHALL have port decim_i, input, 8, decimation: keep 1 of (decim_i+1) samples.
REQ-006 SHALL have port m_data_o, output, 16, packed word {seq[3:0], sample[11:0]} or pad word.
REQ-007 SHALL have ports m_valid_o (output, 1) and m_ready_i (input, 1) forming a ready/valid handshake toward the USB FIFO writer.
REQ-008 SHALL have port m_last_o, output, 1, marks the final word of a 256-word frame.
REQ-009 SHALL have ports busy_o (output, 1), ovf_o (output, 1, sticky overflow) and drop_cnt_o (output, 16, dropped-sample count).

Function
REQ-010 SHALL implement FSM states IDLE, RUN and FLUSH.
REQ-011 SHALL go IDLE->RUN when start_i=1; decim_i is latched at this transition, and the latched value governs the whole run.
REQ-012 On IDLE->RUN, SHALL clear the decimation counter, seq, frame word count, ovf_o and drop_cnt_o.
REQ-013 In RUN, SHALL accept a sample when the decimation counter is 0, reloading it with the latched decim_i; otherwise it decrements. The first sample accepted is the one present in the first RUN cycle.
REQ-014 Each accepted sample SHALL use the current seq and then increment seq modulo 16 (15->0), including samples that are dropped.
REQ-015 An accepted sample SHALL be written to the internal 16-deep FIFO if the FIFO is not full; the frame word count advances only on a write.
REQ-016 If the FIFO is full (count=16), an accepted sample SHALL be dropped even when a read occurs in the same cycle; ovf_o is set, and drop_cnt_o increments, saturating at 16'hFFFF.
REQ-017 The frame word count SHALL run 0..255 and wrap to 0; the word written at count 255 carries last=1.
REQ-018 SHALL go RUN->FLUSH when start_i=0, and no sample is accepted in that cycle.
REQ-019 In FLUSH with frame count != 0, SHALL write pad words 16'h0000 until the frame is complete, with last=1 on the pad at count 255. Pad writes stall while the FIFO is full and are never dropped.
REQ-020 In FLUSH with frame count = 0, SHALL wait for the FIFO to empty and then go to IDLE.
REQ-021 start_i SHALL be ignored in FLUSH; if it is still high on return to IDLE, RUN is re-entered on the next cycle.
REQ-022 The FIFO SHALL be first-word-fall-through: a word written at edge N into an empty FIFO appears on m_data_o/m_valid_o/m_last_o in the cycle after edge N.
REQ-023 A read SHALL occur only on m_valid_o & m_ready_i; m_data_o and m_last_o hold stable while m_valid_o=1 and m_ready_i=0.
REQ-024 busy_o SHALL equal (state != IDLE).

Reset
REQ-025 While rst_n_i=0 at a clk_i edge, SHALL force state=IDLE and empty the FIFO.
REQ-026 Reset SHALL drive m_valid_o=0, m_last_o=0, m_data_o=0, busy_o=0, ovf_o=0, drop_cnt_o=0 and all counters to 0.
REQ-027 Reset asserted mid-frame SHALL discard all buffered words, with no pad and no last emitted.

Structure
REQ-028 Shared package daq_pkg SHALL hold the FSM state enum, FRAME_WORDS=256, FIFO_DEPTH=16 and PAD_WORD=16'h0000.
REQ-029 The FIFO SHALL be a separate sub-module sync_fifo (parameterised width/depth, FWFT, synchronous active-low reset), instantiated once.

Verification
REQ-030 Decimation: decim_i=0, ramp input 0,1,2..., m_ready_i=1 -> words 16'h0000, 16'h1001, 16'h2002 ..., with last on word 256.
REQ-031 Decimation: decim_i=3, ramp input -> samples 0,4,8... with seq 0,1,2...
REQ-032 Overflow: m_ready_i=0, decim_i=0 for 20 cycles -> 16 words stored, ovf_o=1, drop_cnt_o=4; after release, the 17th word read has seq 4 (gap visible).
REQ-033 Stop mid-frame: start_i drops after 10 written words -> 246 pad words 16'h0000 emitted, last on the final pad, then busy_o=0.
REQ-034 Restart: start_i high throughout a FLUSH -> IDLE for one cycle, then RUN with ovf_o and drop_cnt_o cleared.
REQ-035 Reset: reset asserted with 8 words buffered -> m_valid_o=0 on the next cycle, and the next run starts at seq 0.
